// File: rtl/traffic_phase_sched.sv
// Demand-actuated NS/EW phase scheduler: clearance, walk service, emergency pre-emption.
// Latency: lamps/phase registered, change on the same edge as the state. Backpressure: none, sensor inputs free-running.
module traffic_phase_sched #(
  parameter int MIN_GREEN    = 2000,
  parameter int MAX_GREEN    = 10000,
  parameter int YELLOW_TIME  = 1500,
  parameter int ALL_RED_TIME = 500,
  parameter int WALK_TIME    = 1000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       emerg,
  output logic [3:0] NS,
  output logic [3:0] EW,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    NS_G     = 3'd1,
    NS_Y     = 3'd2,
    RED_A    = 3'd3,
    EW_G     = 3'd4,
    EW_Y     = 3'd5,
    RED_B    = 3'd6,
    EMG_RED  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_CNT = CNT_W'(WALK_TIME);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_ns_q, ped_ns_d;
  logic             ped_ew_q, ped_ew_d;
  logic [3:0]       ns_lamp_q, ns_lamp_d;
  logic [3:0]       ew_lamp_q, ew_lamp_d;
  logic [2:0]       phase_q, phase_d;

  logic ns_demand, ew_demand;
  logic enter_ns_g, enter_ew_g;
  logic walk_ns_d, walk_ew_d;

  always_comb begin
    state_d   = state_q;
    ns_demand = ns_car | ped_ns_q;
    ew_demand = ew_car | ped_ew_q;

    case (state_q)
      INIT_RED: begin
        if (emerg)                      state_d = EMG_RED;
        else if (timer_q >= RED_LAST)   state_d = NS_G;
      end
      // A car on our own approach stretches the green only up to MAX_GREEN.
      NS_G: begin
        if (emerg)                      state_d = NS_Y;
        else if (ew_demand && (timer_q >= MIN_LAST) && (!ns_car || (timer_q >= MAX_LAST)))
                                        state_d = NS_Y;
      end
      NS_Y: begin
        if (timer_q >= YEL_LAST)        state_d = emerg ? EMG_RED : RED_A;
      end
      RED_A: begin
        if (emerg)                      state_d = EMG_RED;
        else if (timer_q >= RED_LAST)   state_d = EW_G;
      end
      EW_G: begin
        if (emerg)                      state_d = EW_Y;
        else if (ns_demand && (timer_q >= MIN_LAST) && (!ew_car || (timer_q >= MAX_LAST)))
                                        state_d = EW_Y;
      end
      EW_Y: begin
        if (timer_q >= YEL_LAST)        state_d = emerg ? EMG_RED : RED_B;
      end
      RED_B: begin
        if (emerg)                      state_d = EMG_RED;
        else if (timer_q >= RED_LAST)   state_d = NS_G;
      end
      EMG_RED: begin
        if (!emerg && (timer_q >= RED_LAST)) state_d = NS_G;
      end
      default: state_d = INIT_RED;
    endcase

    // Clearance after pre-emption is counted only once emerg has dropped.
    if ((state_d != state_q) || ((state_q == EMG_RED) && emerg))
      timer_d = '0;
    else if (timer_q != '1)
      timer_d = timer_q + CNT_W'(1);
    else
      timer_d = timer_q;

    enter_ns_g = (state_d == NS_G) && (state_q != NS_G);
    enter_ew_g = (state_d == EW_G) && (state_q != EW_G);

    ped_ns_d = ped_ns | (ped_ns_q & ~enter_ns_g);
    ped_ew_d = ped_ew | (ped_ew_q & ~enter_ew_g);

    walk_ns_d = enter_ns_g ? ped_ns_q
              : ((state_d == NS_G) && ns_lamp_q[3] && (timer_d < WALK_CNT));
    walk_ew_d = enter_ew_g ? ped_ew_q
              : ((state_d == EW_G) && ew_lamp_q[3] && (timer_d < WALK_CNT));

    ns_lamp_d = {walk_ns_d, state_d == NS_G, state_d == NS_Y,
                 (state_d != NS_G) && (state_d != NS_Y)};
    ew_lamp_d = {walk_ew_d, state_d == EW_G, state_d == EW_Y,
                 (state_d != EW_G) && (state_d != EW_Y)};
    phase_d   = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT_RED;
      timer_q   <= '0;
      ped_ns_q  <= 1'b0;
      ped_ew_q  <= 1'b0;
      ns_lamp_q <= 4'b0001;
      ew_lamp_q <= 4'b0001;
      phase_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ped_ns_q  <= ped_ns_d;
      ped_ew_q  <= ped_ew_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
      phase_q   <= phase_d;
    end
  end

  assign NS    = ns_lamp_q;
  assign EW    = ew_lamp_q;
  assign phase = phase_q;

endmodule
